// File: rtl/mac_row_collector_if.sv
`default_nettype none
// ============================================================================
//  Module      : mac_row_collector_if
//  Description : Handshake bundle between the MAC array, the row collector
//                and the write-back stage. "slave" is the collector's view;
//                "master" is the view of the surrounding logic.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mac_row_collector_if #(
  parameter int DW = 12,
  parameter int N  = 8
);
  logic                   in_valid;
  logic [3:0]             in_idx;
  logic [N*DW-1:0]        in_data;
  logic                   in_finish;
  logic                   out_ready;
  logic                   out_valid;
  logic [$clog2(N)-1:0]   out_row;
  logic [N*DW-1:0]        out_data;
  logic                   out_last;
  logic                   busy;
  logic                   err_drop;

  modport master (
    output in_valid, in_idx, in_data, in_finish, out_ready,
    input  out_valid, out_row, out_data, out_last, busy, err_drop
  );

  modport slave (
    input  in_valid, in_idx, in_data, in_finish, out_ready,
    output out_valid, out_row, out_data, out_last, busy, err_drop
  );
endinterface
`default_nettype wire

// File: rtl/mac_row_collector.sv
`default_nettype none
// ============================================================================
//  Module      : mac_row_collector
//  Description : Collects column-serial MAC result rows into 8x8 frames held
//                in a two-bank ping-pong buffer and drains each frame row by
//                row over valid/ready. Frames arriving while both banks are
//                occupied are dropped whole and flagged in err_drop.
//                Optional macro MAC_ROW_COLLECTOR_POOL_EN: drain emits N/2
//                beats of 2x2 max-pooled data instead of N raw rows.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_row_collector #(
  parameter int DW = 12,
  parameter int N  = 8
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  mac_row_collector_if.slave bus
);

  localparam int c_rw = $clog2(N);
  localparam logic [c_rw-1:0] c_last_col = c_rw'(N - 1);
`ifdef MAC_ROW_COLLECTOR_POOL_EN
  localparam logic [c_rw-1:0] c_last_beat = c_rw'(N / 2 - 1);
`else
  localparam logic [c_rw-1:0] c_last_beat = c_rw'(N - 1);
`endif

  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_send = 1'b1;

  // ---------------------------------------------------------------- state
  logic [c_rw-1:0]       r_col;
  logic                  r_in_frame;
  logic                  r_drop;
  logic                  r_wr_bank;
  logic                  r_rd_bank;
  logic [1:0]            r_full;
  logic [1:0][N-1:0]     r_mask;
  logic [N*DW-1:0]       r_mem [2][N];
  logic [0:0]            r_state;
  logic [c_rw-1:0]       r_out_row;
  logic                  r_err_drop;

  // ---------------------------------------------------------------- control
  logic            w_beat;
  logic            w_drain_done;
  logic            w_bank_free;
  logic            w_drop_cur;
  logic            w_capture;
  logic            w_close;
  logic [c_rw-1:0] w_idx;
  logic [N*DW-1:0] w_row_out;

  assign w_idx        = bus.in_idx[c_rw-1:0];
  assign w_beat       = (r_state == c_st_send) && bus.out_ready;
  assign w_drain_done = w_beat && (r_out_row == c_last_beat);
  // A bank finishing its drain this very cycle counts as free for a new frame.
  assign w_bank_free  = !r_full[r_wr_bank] ||
                        (w_drain_done && (r_rd_bank == r_wr_bank));
  // Drop decision is taken at frame start and held until the frame closes.
  assign w_drop_cur   = r_in_frame ? r_drop : !w_bank_free;
  assign w_capture    = bus.in_valid && (r_col == c_last_col) && !w_drop_cur;
  assign w_close      = bus.in_valid && bus.in_finish;

  // Frame tracking: column counter, frame-in-progress, drop flag, write bank.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col      <= '0;
      r_in_frame <= 1'b0;
      r_drop     <= 1'b0;
      r_wr_bank  <= 1'b0;
      r_err_drop <= 1'b0;
    end else if (bus.in_valid) begin
      if (!r_in_frame && !w_bank_free) begin
        r_err_drop <= 1'b1;
      end
      if (bus.in_finish) begin
        r_col      <= '0;
        r_in_frame <= 1'b0;
        r_drop     <= 1'b0;
        // A dropped frame never occupied the bank, so keep pointing at it;
        // this keeps write order and drain order in step.
        if (!w_drop_cur) begin
          r_wr_bank <= ~r_wr_bank;
        end
      end else begin
        r_col      <= r_col + 1'b1;
        r_in_frame <= 1'b1;
        r_drop     <= w_drop_cur;
      end
    end
  end

  // Bank bookkeeping: drain clears first so a same-cycle fill of that bank wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_full <= '0;
      r_mask <= '0;
    end else begin
      if (w_drain_done) begin
        r_full[r_rd_bank] <= 1'b0;
        r_mask[r_rd_bank] <= '0;
      end
      if (w_capture) begin
        r_mask[r_wr_bank][w_idx] <= 1'b1;
      end
      if (w_close && !w_drop_cur) begin
        r_full[r_wr_bank] <= 1'b1;
      end
    end
  end

  // Row storage; contents are qualified by the mask so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_mem[r_wr_bank][w_idx] <= bus.in_data;
    end
  end

  // Drain FSM: send a full bank beat by beat, chaining straight into the
  // other bank when it is already waiting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= c_st_idle;
      r_out_row <= '0;
      r_rd_bank <= 1'b0;
    end else if (r_state == c_st_idle) begin
      if (r_full[r_rd_bank]) begin
        r_state   <= c_st_send;
        r_out_row <= '0;
      end
    end else if (w_beat) begin
      if (r_out_row == c_last_beat) begin
        r_rd_bank <= ~r_rd_bank;
        r_out_row <= '0;
        r_state   <= r_full[~r_rd_bank] ? c_st_send : c_st_idle;
      end else begin
        r_out_row <= r_out_row + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- read path
`ifdef MAC_ROW_COLLECTOR_POOL_EN
  logic [c_rw-1:0] w_idx_a;
  logic [c_rw-1:0] w_idx_b;
  logic [N*DW-1:0] w_row_a;
  logic [N*DW-1:0] w_row_b;
  logic [N*DW-1:0] w_pool;
  logic            w_unused;

  assign w_idx_a  = {r_out_row[c_rw-2:0], 1'b0};
  assign w_idx_b  = {r_out_row[c_rw-2:0], 1'b1};
  assign w_row_a  = r_mask[r_rd_bank][w_idx_a] ? r_mem[r_rd_bank][w_idx_a] : '0;
  assign w_row_b  = r_mask[r_rd_bank][w_idx_b] ? r_mem[r_rd_bank][w_idx_b] : '0;
  assign w_unused = ^{bus.in_idx, r_out_row[c_rw-1]};

  for (genvar c = 0; c < N; c++) begin : g_pool
    if (c < N / 2) begin : g_max
      logic [DW-1:0] w_a0, w_a1, w_b0, w_b1, w_ma, w_mb;
      assign w_a0 = w_row_a[(2*c)*DW +: DW];
      assign w_a1 = w_row_a[(2*c+1)*DW +: DW];
      assign w_b0 = w_row_b[(2*c)*DW +: DW];
      assign w_b1 = w_row_b[(2*c+1)*DW +: DW];
      assign w_ma = (w_a0 > w_a1) ? w_a0 : w_a1;
      assign w_mb = (w_b0 > w_b1) ? w_b0 : w_b1;
      assign w_pool[c*DW +: DW] = (w_ma > w_mb) ? w_ma : w_mb;
    end else begin : g_zero
      assign w_pool[c*DW +: DW] = '0;
    end
  end

  assign w_row_out = w_pool;
`else
  logic w_unused;

  assign w_unused  = ^bus.in_idx;
  assign w_row_out = r_mask[r_rd_bank][r_out_row] ? r_mem[r_rd_bank][r_out_row] : '0;
`endif

  // ---------------------------------------------------------------- outputs
  assign bus.out_valid = (r_state == c_st_send);
  assign bus.out_row   = r_out_row;
  assign bus.out_last  = (r_state == c_st_send) && (r_out_row == c_last_beat);
  assign bus.out_data  = (r_state == c_st_send) ? w_row_out : '0;
  assign bus.busy      = (|r_full) || (r_in_frame && !r_drop);
  assign bus.err_drop  = r_err_drop;

endmodule
`default_nettype wire

// File: tb/tb_mac_row_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_row_collector
//  Description : Scoreboard bench for mac_row_collector. Stimulus pushes the
//                expected drain beats; a negedge monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_row_collector;

  localparam int DW = 12;
  localparam int N  = 8;
`ifdef MAC_ROW_COLLECTOR_POOL_EN
  localparam int NB = N / 2;
`else
  localparam int NB = N;
`endif

  typedef struct {
    logic [2:0]      row;
    logic [N*DW-1:0] data;
    logic            last;
  } beat_t;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  beat_t sb[$];

  mac_row_collector_if #(.DW(DW), .N(N)) vif ();

  mac_row_collector #(.DW(DW), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (vif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected beats of one frame: row r element c = base + 8r + c when row r
  // was completed (8(r+1) valids seen), else zero.
  task automatic push_frame(input int base, input int nvalid);
    logic [DW-1:0]   m [N][N];
    logic [N*DW-1:0] d;
    logic [DW-1:0]   mx;
    beat_t           e;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        m[r][c] = ((r + 1) * N <= nvalid) ? DW'(base + N * r + c) : '0;
    for (int b = 0; b < NB; b++) begin
      d = '0;
`ifdef MAC_ROW_COLLECTOR_POOL_EN
      for (int c = 0; c < N / 2; c++) begin
        mx = m[2*b][2*c];
        if (m[2*b][2*c+1]   > mx) mx = m[2*b][2*c+1];
        if (m[2*b+1][2*c]   > mx) mx = m[2*b+1][2*c];
        if (m[2*b+1][2*c+1] > mx) mx = m[2*b+1][2*c+1];
        d[c*DW +: DW] = mx;
      end
`else
      mx = '0;
      for (int c = 0; c < N; c++) d[c*DW +: DW] = m[b][c] | mx;
`endif
      e.row  = 3'(b);
      e.data = d;
      e.last = (b == NB - 1);
      sb.push_back(e);
    end
  endtask

  // Drives nvalid MAC elements through a model of the MAC shift register.
  task automatic send_frame(input int base, input int nvalid);
    logic [N*DW-1:0] sr;
    sr = '0;
    for (int i = 0; i < nvalid; i++) begin
      sr = {DW'(base + i), sr[N*DW-1:DW]};
      vif.in_valid  = 1'b1;
      vif.in_idx    = 4'(i / N);
      vif.in_data   = sr;
      vif.in_finish = (i == nvalid - 1);
      @(posedge clk); #1;
    end
    vif.in_valid  = 1'b0;
    vif.in_finish = 1'b0;
  endtask

  task automatic wait_sb(input int target, input string name);
    int k;
    k = 0;
    while (sb.size() > target && k < 400) begin
      @(negedge clk); #1;
      k++;
    end
    chk(name, 128'(sb.size() > target), 128'(0));
  endtask

  // Monitor: pop on every transfer, check hold during stalls and idle zeros.
  initial begin
    bit              prev_stall;
    logic [2:0]      p_row;
    logic [N*DW-1:0] p_data;
    logic            p_last;
    beat_t           e;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", 128'(vif.out_valid), 128'(1));
          chk("stall_row",   128'(vif.out_row),   128'(p_row));
          chk("stall_data",  128'(vif.out_data),  128'(p_data));
          chk("stall_last",  128'(vif.out_last),  128'(p_last));
        end
        if (vif.out_valid === 1'b1) begin
          if (vif.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL unexpected_beat: got row %0d, expected no beat", vif.out_row);
            end else begin
              e = sb.pop_front();
              chk("beat_row",  128'(vif.out_row),  128'(e.row));
              chk("beat_data", 128'(vif.out_data), 128'(e.data));
              chk("beat_last", 128'(vif.out_last), 128'(e.last));
            end
          end
        end else begin
          chk("idle_data_zero", 128'(vif.out_data), 128'(0));
        end
        prev_stall = (vif.out_valid === 1'b1) && (vif.out_ready !== 1'b1);
        p_row  = vif.out_row;
        p_data = vif.out_data;
        p_last = vif.out_last;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit tog_run;
    rst_n         = 1'b0;
    vif.in_valid  = 1'b0;
    vif.in_idx    = '0;
    vif.in_data   = '0;
    vif.in_finish = 1'b0;
    vif.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("rst_out_valid", 128'(vif.out_valid), 128'(0));
    chk("rst_out_row",   128'(vif.out_row),   128'(0));
    chk("rst_out_last",  128'(vif.out_last),  128'(0));
    chk("rst_out_data",  128'(vif.out_data),  128'(0));
    chk("rst_busy",      128'(vif.busy),      128'(0));
    chk("rst_err_drop",  128'(vif.err_drop),  128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1) Single frame, out_ready held high
    vif.out_ready = 1'b1;
    push_frame(0, 64);
    send_frame(0, 64);
    @(negedge clk);
    chk("lat_valid_low", 128'(vif.out_valid), 128'(0));
    chk("lat_busy",      128'(vif.busy),      128'(1));
    for (int i = 0; i < NB; i++) begin
      @(negedge clk);
      chk("burst_valid", 128'(vif.out_valid), 128'(1));
    end
    @(negedge clk);
    chk("burst_end_valid", 128'(vif.out_valid), 128'(0));
    chk("burst_end_busy",  128'(vif.busy),      128'(0));
    chk("single_sb_empty", 128'(sb.size()),     128'(0));

    // 2) Back-pressure: out_ready toggles 1,0,1,0 during the drain
    @(posedge clk); #1;
    push_frame(0, 64);
    tog_run = 1'b1;
    fork
      begin
        send_frame(0, 64);
        wait_sb(0, "bp_drain_timeout");
        tog_run = 1'b0;
      end
      begin
        while (tog_run) begin
          vif.out_ready = ~vif.out_ready;
          @(posedge clk); #1;
        end
      end
    join
    @(negedge clk); #1;
    chk("bp_busy_after", 128'(vif.busy),      128'(0));
    chk("bp_valid_after",128'(vif.out_valid), 128'(0));
    vif.out_ready = 1'b1;

    // 3) Partial frame: 20 valids
    @(posedge clk); #1;
    push_frame(0, 20);
    send_frame(0, 20);
    wait_sb(0, "partial_timeout");
    @(negedge clk); #1;
    chk("partial_busy", 128'(vif.busy), 128'(0));

    // 4) Ping-pong with drop of the third frame
    @(posedge clk); #1;
    vif.out_ready = 1'b0;
    push_frame(0, 64);
    push_frame(100, 64);
    send_frame(0, 64);
    send_frame(100, 64);
    chk("pp_err_before", 128'(vif.err_drop), 128'(0));
    chk("pp_busy_full",  128'(vif.busy),     128'(1));
    fork
      send_frame(200, 64);
      begin
        @(posedge clk); #2;
        chk("pp_err_set", 128'(vif.err_drop), 128'(1));
        vif.out_ready = 1'b1;
      end
    join
    wait_sb(0, "pp_drain_timeout");
    repeat (2) @(negedge clk);
    #1;
    chk("pp_err_sticky", 128'(vif.err_drop),  128'(1));
    chk("pp_busy_after", 128'(vif.busy),      128'(0));
    chk("pp_valid_after",128'(vif.out_valid), 128'(0));

    // 5) Reset mid-drain after beat 3, then a fresh frame from bank 0
    @(posedge clk); #1;
    push_frame(0, 64);
    send_frame(0, 64);
    wait_sb(NB / 2, "rst_wait_timeout");
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_rst_valid",    128'(vif.out_valid), 128'(0));
    chk("mid_rst_err_drop", 128'(vif.err_drop),  128'(0));
    chk("mid_rst_busy",     128'(vif.busy),      128'(0));
    chk("mid_rst_row",      128'(vif.out_row),   128'(0));
    push_frame(50, 64);
    send_frame(50, 64);
    wait_sb(0, "post_rst_timeout");
    @(negedge clk); #1;
    chk("post_rst_busy", 128'(vif.busy), 128'(0));

    chk("final_sb_empty", 128'(sb.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
